// File: rtl/sargantana_icache_mshr.sv
// Purpose: miss-status holding registers for the icache; tracks up to N_MSHR line fills, merges secondary misses, reassembles beats.
// Latency: accepted miss -> ifill request next cycle at the earliest; last beat -> array fill request next cycle at the earliest.
// Backpressure: miss_ready_o drops when full or on kill/flush; ifill and fill requests hold until their handshake; responses are never stalled.
module sargantana_icache_mshr #(
    parameter int N_MSHR       = 4,
    parameter int LINE_ADDR_W  = 34,
    parameter int N_WAY        = 4,
    parameter int BEAT_W       = 256,
    parameter int N_BEATS      = 2,
    localparam int WAY_W       = $clog2(N_WAY),
    localparam int ID_W        = $clog2(N_MSHR),
    localparam int BIDX_W      = (N_BEATS > 1) ? $clog2(N_BEATS) : 1,
    localparam int LINE_W      = N_BEATS * BEAT_W
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   kill_i,
    input  logic                   flush_i,
    input  logic                   miss_valid_i,
    output logic                   miss_ready_o,
    input  logic [LINE_ADDR_W-1:0] miss_paddr_i,
    input  logic [WAY_W-1:0]       miss_way_i,
    output logic                   miss_merged_o,
    output logic                   ifill_req_valid_o,
    input  logic                   ifill_req_ready_i,
    output logic [LINE_ADDR_W-1:0] ifill_req_paddr_o,
    output logic [ID_W-1:0]        ifill_req_id_o,
    input  logic                   ifill_resp_valid_i,
    input  logic [ID_W-1:0]        ifill_resp_id_i,
    input  logic [BIDX_W-1:0]      ifill_resp_beat_i,
    input  logic [BEAT_W-1:0]      ifill_resp_data_i,
    input  logic                   inv_valid_i,
    input  logic [LINE_ADDR_W-1:0] inv_paddr_i,
    output logic                   fill_valid_o,
    input  logic                   fill_ready_i,
    output logic [LINE_ADDR_W-1:0] fill_paddr_o,
    output logic [WAY_W-1:0]       fill_way_o,
    output logic [LINE_W-1:0]      fill_data_o,
    output logic [ID_W:0]          outstanding_o,
    output logic                   busy_o
);

    typedef enum logic [2:0] {
        S_FREE,
        S_WAIT_SEND,
        S_WAIT_RESP,
        S_FILL,
        S_WRITE
    } state_e;

    state_e                 state [N_MSHR];
    logic [LINE_ADDR_W-1:0] paddr [N_MSHR];
    logic [WAY_W-1:0]       way   [N_MSHR];
    logic [N_BEATS-1:0]     bmask [N_MSHR];
    logic [LINE_W-1:0]      data  [N_MSHR];
    logic [N_MSHR-1:0]      drop;

    logic                   kill_any;
    logic                   any_free;
    logic                   match;
    logic                   accept;
    logic                   req_found;
    logic                   fill_found;
    logic [ID_W-1:0]        alloc_idx;
    logic [ID_W-1:0]        req_idx;
    logic [ID_W-1:0]        fill_idx;
    logic [ID_W:0]          outstanding;
    logic [N_MSHR-1:0]      inv_hit;
    logic [N_MSHR-1:0]      beat_hit;
    logic [N_MSHR-1:0]      last_beat;
    logic [N_MSHR-1:0]      drop_nx;
    logic [N_BEATS-1:0]     mask_nx [N_MSHR];

    // Per-entry lookups, lowest-index arbitration and next drop/beat-mask values.
    always_comb begin
        kill_any    = kill_i | flush_i;
        any_free    = 1'b0;
        match       = 1'b0;
        req_found   = 1'b0;
        fill_found  = 1'b0;
        alloc_idx   = '0;
        req_idx     = '0;
        fill_idx    = '0;
        outstanding = '0;
        inv_hit     = '0;
        beat_hit    = '0;
        last_beat   = '0;
        drop_nx     = '0;
        for (int i = 0; i < N_MSHR; i++) begin
            mask_nx[i] = bmask[i];
            inv_hit[i] = inv_valid_i && (state[i] != S_FREE) && (paddr[i] == inv_paddr_i);
            if ((state[i] == S_FREE) && !any_free) begin
                any_free  = 1'b1;
                alloc_idx = ID_W'(i);
            end
            if ((state[i] != S_FREE) && !drop[i] && (paddr[i] == miss_paddr_i))
                match = 1'b1;
            if ((state[i] == S_WAIT_SEND) && !req_found) begin
                req_found = 1'b1;
                req_idx   = ID_W'(i);
            end
            // An invalidated WRITE entry is withdrawn in the same cycle.
            if ((state[i] == S_WRITE) && !inv_hit[i] && !fill_found) begin
                fill_found = 1'b1;
                fill_idx   = ID_W'(i);
            end
            if (state[i] != S_FREE)
                outstanding = outstanding + (ID_W+1)'(1);
            drop_nx[i] = drop[i] | inv_hit[i] |
                         (kill_any && ((state[i] == S_WAIT_RESP) || (state[i] == S_FILL)));
            beat_hit[i] = ifill_resp_valid_i && (ifill_resp_id_i == ID_W'(i)) &&
                          ((state[i] == S_WAIT_RESP) || (state[i] == S_FILL)) &&
                          !bmask[i][ifill_resp_beat_i];
            if (beat_hit[i])
                mask_nx[i][ifill_resp_beat_i] = 1'b1;
            last_beat[i] = beat_hit[i] && (&mask_nx[i]);
        end
        // A same-cycle invalidation of the missing line wins: never merge into it.
        if (inv_valid_i && (inv_paddr_i == miss_paddr_i))
            match = 1'b0;
    end

    assign miss_ready_o      = rstn_i && !kill_any && (match || any_free);
    assign accept            = miss_valid_i && miss_ready_o;
    assign miss_merged_o     = accept && match;
    assign ifill_req_valid_o = rstn_i && req_found && !kill_any;
    assign ifill_req_paddr_o = ifill_req_valid_o ? paddr[req_idx] : '0;
    assign ifill_req_id_o    = ifill_req_valid_o ? req_idx : '0;
    assign fill_valid_o      = rstn_i && fill_found && !flush_i;
    assign fill_paddr_o      = fill_valid_o ? paddr[fill_idx] : '0;
    assign fill_way_o        = fill_valid_o ? way[fill_idx] : '0;
    assign fill_data_o       = fill_valid_o ? data[fill_idx] : '0;
    assign outstanding_o     = outstanding;
    assign busy_o            = (outstanding != '0);

    // Entry lifecycle: allocate, issue, collect beats, write back, or drop.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < N_MSHR; i++) begin
                state[i] <= S_FREE;
                bmask[i] <= '0;
            end
            drop <= '0;
        end else begin
            for (int i = 0; i < N_MSHR; i++) begin
                case (state[i])
                    S_FREE: begin
                        if (accept && !match && (alloc_idx == ID_W'(i))) begin
                            state[i] <= S_WAIT_SEND;
                            paddr[i] <= miss_paddr_i;
                            way[i]   <= miss_way_i;
                            drop[i]  <= 1'b0;
                            bmask[i] <= '0;
                        end
                    end
                    S_WAIT_SEND: begin
                        if (kill_any) begin
                            state[i] <= S_FREE;
                            drop[i]  <= 1'b0;
                        end else begin
                            drop[i] <= drop_nx[i];
                            if (ifill_req_valid_o && ifill_req_ready_i && (req_idx == ID_W'(i)))
                                state[i] <= S_WAIT_RESP;
                        end
                    end
                    S_WAIT_RESP, S_FILL: begin
                        bmask[i] <= mask_nx[i];
                        drop[i]  <= drop_nx[i];
                        if (last_beat[i]) begin
                            if (drop_nx[i]) begin
                                state[i] <= S_FREE;
                                drop[i]  <= 1'b0;
                                bmask[i] <= '0;
                            end else begin
                                state[i] <= S_WRITE;
                            end
                        end else if (beat_hit[i]) begin
                            state[i] <= S_FILL;
                        end
                    end
                    S_WRITE: begin
                        if (flush_i || inv_hit[i] ||
                            (fill_valid_o && fill_ready_i && (fill_idx == ID_W'(i)))) begin
                            state[i] <= S_FREE;
                            drop[i]  <= 1'b0;
                            bmask[i] <= '0;
                        end
                    end
                    default: state[i] <= S_FREE;
                endcase
            end
        end
    end

    // Line storage: each accepted beat lands in its slot; no reset needed.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < N_MSHR; i++) begin
            if (beat_hit[i])
                data[i][int'(ifill_resp_beat_i)*BEAT_W +: BEAT_W] <= ifill_resp_data_i;
        end
    end

endmodule

// File: tb/tb_sargantana_icache_mshr.sv
// Purpose: scoreboard bench for sargantana_icache_mshr: directed scenarios then randomized traffic against a reference model.
// Latency: model predictions compared one time unit after each stimulus update; completed lines checked by a separate monitor.
// Backpressure: bench randomizes ifill_req_ready and fill_ready; the L2 model replays beats in random order.
module tb_sargantana_icache_mshr;
    localparam int N  = 4;
    localparam int AW = 34;
    localparam int WW = 2;
    localparam int BW = 256;
    localparam int NB = 2;
    localparam int IW = 2;
    localparam int LW = NB * BW;

    typedef struct packed {
        logic [AW-1:0] paddr;
        logic [WW-1:0] way;
        logic [LW-1:0] line;
    } fill_t;

    logic          clk = 1'b0;
    logic          rstn, kill, flush, miss_valid, miss_ready, miss_merged;
    logic [AW-1:0] miss_paddr, req_paddr, inv_paddr, fill_paddr;
    logic [WW-1:0] miss_way, fill_way;
    logic          req_valid, req_ready, resp_valid, inv_valid, fill_valid, fill_ready, busy;
    logic [IW-1:0] req_id, resp_id;
    logic          resp_beat;
    logic [BW-1:0] resp_data;
    logic [LW-1:0] fill_data;
    logic [IW:0]   outstanding;

    always #5 clk = ~clk;

    sargantana_icache_mshr dut (
        .clk_i(clk), .rstn_i(rstn), .kill_i(kill), .flush_i(flush),
        .miss_valid_i(miss_valid), .miss_ready_o(miss_ready), .miss_paddr_i(miss_paddr),
        .miss_way_i(miss_way), .miss_merged_o(miss_merged),
        .ifill_req_valid_o(req_valid), .ifill_req_ready_i(req_ready),
        .ifill_req_paddr_o(req_paddr), .ifill_req_id_o(req_id),
        .ifill_resp_valid_i(resp_valid), .ifill_resp_id_i(resp_id),
        .ifill_resp_beat_i(resp_beat), .ifill_resp_data_i(resp_data),
        .inv_valid_i(inv_valid), .inv_paddr_i(inv_paddr),
        .fill_valid_o(fill_valid), .fill_ready_i(fill_ready), .fill_paddr_o(fill_paddr),
        .fill_way_o(fill_way), .fill_data_o(fill_data),
        .outstanding_o(outstanding), .busy_o(busy)
    );

    // Reference model: one record per slot plus the expected-line queue.
    bit            m_used [N];
    bit            m_sent [N];
    bit            m_done [N];
    bit            m_drop [N];
    bit [NB-1:0]   m_got  [N];
    logic [AW-1:0] m_paddr[N];
    logic [WW-1:0] m_way  [N];
    logic [LW-1:0] m_line [N];
    fill_t         exp_q[$];
    // L2 model: which beats are still owed per id.
    bit            l2_pend[N];
    bit [NB-1:0]   l2_left[N];

    int n_cmp = 0;
    int n_bad = 0;
    int rst_cyc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        kill = 0; flush = 0; miss_valid = 0; miss_paddr = '0; miss_way = '0;
        req_ready = 0; resp_valid = 0; resp_id = '0; resp_beat = 0; resp_data = '0;
        inv_valid = 0; inv_paddr = '0; fill_ready = 0;
    endtask

    task automatic do_miss(input logic [AW-1:0] a, input logic [WW-1:0] w);
        idle();
        miss_valid = 1; miss_paddr = a; miss_way = w;
    endtask

    function automatic logic [BW-1:0] rand_beat();
        logic [BW-1:0] v;
        for (int k = 0; k < BW/32; k++) v[k*32 +: 32] = $urandom();
        return v;
    endfunction

    task automatic send_beat(input int id, input int b);
        resp_valid = 1; resp_id = IW'(id); resp_beat = b[0]; resp_data = rand_beat();
        l2_left[id][b] = 1'b0;
        if (l2_left[id] == '0) l2_pend[id] = 0;
    endtask

    task automatic l2_drive(input int pct, input int spur_pct);
        int ids[$];
        int id, b;
        for (int e = 0; e < N; e++) if (l2_pend[e]) ids.push_back(e);
        if (ids.size() > 0 && $urandom_range(99) < pct) begin
            id = ids[$urandom_range(ids.size()-1)];
            do b = $urandom_range(NB-1); while (!l2_left[id][b]);
            send_beat(id, b);
        end else if ($urandom_range(99) < spur_pct) begin
            resp_valid = 1; resp_id = IW'($urandom_range(N-1));
            resp_beat = 1'($urandom_range(NB-1)); resp_data = rand_beat();
        end
    endtask

    // Predict this cycle's outputs from the model, compare, then advance the model across the edge.
    task automatic check_model();
        bit kk, match, e_ready, e_rv, e_fv, nd;
        bit ih[N];
        int lf, rs, fs, cnt;
        fill_t f;
        if (rstn !== 1'b1) begin
            if (rst_cyc > 0) begin
                chk("rst_miss_ready", miss_ready, 0);
                chk("rst_merged", miss_merged, 0);
                chk("rst_req_valid", req_valid, 0);
                chk("rst_fill_valid", fill_valid, 0);
                chk("rst_outstanding", outstanding, 0);
                chk("rst_busy", busy, 0);
            end
            rst_cyc++;
            for (int e = 0; e < N; e++) begin
                m_used[e] = 0; l2_pend[e] = 0; l2_left[e] = '0;
            end
            exp_q.delete();
            return;
        end
        rst_cyc = 0;
        kk = kill | flush;
        lf = -1; rs = -1; fs = -1; cnt = 0; match = 0;
        for (int e = 0; e < N; e++) begin
            ih[e] = inv_valid && m_used[e] && (m_paddr[e] == inv_paddr);
            if (!m_used[e] && lf < 0) lf = e;
            if (m_used[e] && !m_drop[e] && m_paddr[e] == miss_paddr) match = 1;
            if (m_used[e] && !m_sent[e] && rs < 0) rs = e;
            if (m_used[e] && m_done[e] && !ih[e] && fs < 0) fs = e;
            if (m_used[e]) cnt++;
        end
        if (inv_valid && inv_paddr == miss_paddr) match = 0;
        e_ready = !kk && (match || lf >= 0);
        e_rv = (rs >= 0) && !kk;
        e_fv = (fs >= 0) && !flush;
        chk("miss_ready", miss_ready, e_ready);
        chk("miss_merged", miss_merged, miss_valid && e_ready && match);
        chk("req_valid", req_valid, e_rv);
        if (e_rv && req_valid) begin
            chk("req_paddr", req_paddr, m_paddr[rs]);
            chk("req_id", req_id, rs);
        end
        chk("fill_valid", fill_valid, e_fv);
        if (e_fv && fill_valid) begin
            chk("fill_paddr", fill_paddr, m_paddr[fs]);
            chk("fill_way", fill_way, m_way[fs]);
        end
        chk("outstanding", outstanding, cnt);
        chk("busy", busy, cnt != 0);
        for (int e = 0; e < N; e++) begin
            if (!m_used[e]) begin
                if (miss_valid && e_ready && !match && e == lf) begin
                    m_used[e] = 1; m_sent[e] = 0; m_done[e] = 0; m_drop[e] = 0; m_got[e] = '0;
                    m_paddr[e] = miss_paddr; m_way[e] = miss_way;
                end
            end else if (!m_sent[e]) begin
                if (kk) m_used[e] = 0;
                else begin
                    if (ih[e]) m_drop[e] = 1;
                    if (e_rv && req_ready && rs == e) begin
                        m_sent[e] = 1; l2_pend[e] = 1; l2_left[e] = '1;
                    end
                end
            end else if (!m_done[e]) begin
                nd = m_drop[e] | kk | ih[e];
                if (resp_valid && resp_id == IW'(e) && !m_got[e][resp_beat]) begin
                    m_got[e][resp_beat] = 1;
                    m_line[e][int'(resp_beat)*BW +: BW] = resp_data;
                    if (&m_got[e]) begin
                        if (nd) m_used[e] = 0;
                        else m_done[e] = 1;
                    end
                end
                m_drop[e] = nd;
            end else begin
                if (e_fv && fill_ready && fs == e) begin
                    f.paddr = m_paddr[e]; f.way = m_way[e]; f.line = m_line[e];
                    exp_q.push_back(f);
                    m_used[e] = 0;
                end else if (flush || ih[e]) begin
                    m_used[e] = 0;
                end
            end
        end
    endtask

    task automatic step();
        #1 check_model();
        @(negedge clk);
    endtask

    // Monitor: every accepted array write must match the oldest expected line.
    initial begin
        fill_t x;
        forever begin
            @(negedge clk);
            #3;
            if (rstn === 1'b1 && fill_valid === 1'b1 && fill_ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL fill_unexpected: got paddr %0h with no line expected at %0t", fill_paddr, $time);
                end else begin
                    x = exp_q.pop_front();
                    if (fill_paddr !== x.paddr || fill_way !== x.way || fill_data !== x.line) begin
                        n_bad++;
                        $display("FAIL fill_line: got paddr %0h way %0d data %0h expected paddr %0h way %0d data %0h",
                                 fill_paddr, fill_way, fill_data, x.paddr, x.way, x.line);
                    end
                end
            end
        end
    end

    initial begin
        logic [BW-1:0] b0, b1;
        int t2_ids[4];
        int guard;
        bit busy_m;
        t2_ids = '{2, 0, 3, 1};
        rstn = 0;
        idle();
        @(negedge clk);
        repeat (3) step();
        rstn = 1;

        // 1: single miss, in-order beats, line assembled as {beat1,beat0}.
        do_miss('h1000, 2); step();
        idle(); req_ready = 1;
        #1 chk("t1_req_valid", req_valid, 1); chk("t1_req_id", req_id, 0); chk("t1_req_paddr", req_paddr, 'h1000);
        step();
        idle(); send_beat(0, 0); b0 = resp_data; step();
        idle(); send_beat(0, 1); b1 = resp_data; step();
        idle(); fill_ready = 1;
        #1 chk("t1_fill_valid", fill_valid, 1); chk("t1_fill_paddr", fill_paddr, 'h1000); chk("t1_fill_way", fill_way, 2);
        n_cmp++;
        if (fill_data !== {b1, b0}) begin
            n_bad++;
            $display("FAIL t1_fill_data: got %0h expected %0h", fill_data, {b1, b0});
        end
        step();
        idle(); #1 chk("t1_outstanding", outstanding, 0); step();

        // 2: fill all slots, reject when full, out-of-order reversed responses.
        for (int k = 0; k < 4; k++) begin do_miss(AW'((k+1)*'h10), WW'(k)); step(); end
        do_miss('h50, 0);
        #1 chk("t2_full_ready", miss_ready, 0); chk("t2_outstanding", outstanding, 4);
        step();
        for (int k = 0; k < 4; k++) begin
            idle(); req_ready = 1;
            #1 chk("t2_req_id", req_id, k);
            step();
        end
        foreach (t2_ids[j]) begin
            for (int b = NB-1; b >= 0; b--) begin idle(); fill_ready = 1; send_beat(t2_ids[j], b); step(); end
        end
        repeat (3) begin idle(); fill_ready = 1; step(); end

        // 3: secondary miss merges into the in-flight entry.
        do_miss('h10, 1); step();
        idle(); req_ready = 1; step();
        do_miss('h10, 3);
        #1 chk("t3_merged", miss_merged, 1);
        step();
        idle(); #1 chk("t3_outstanding", outstanding, 1); step();
        for (int b = 0; b < NB; b++) begin idle(); send_beat(0, b); step(); end
        repeat (3) begin idle(); fill_ready = 1; step(); end

        // 4: kill with two entries waiting on L2 and one unsent.
        do_miss('h100, 0); step();
        do_miss('h140, 1); req_ready = 1; step();
        do_miss('h180, 2); req_ready = 1; step();
        idle(); kill = 1; req_ready = 1;
        #1 chk("t4_req_masked", req_valid, 0);
        step();
        idle(); #1 chk("t4_outstanding", outstanding, 2); step();
        for (int id = 0; id < 2; id++)
            for (int b = 0; b < NB; b++) begin idle(); fill_ready = 1; send_beat(id, b); step(); end
        idle(); #1 chk("t4_drained", outstanding, 0); step();

        // 5: invalidation and new miss to the same line while the old one is filling.
        do_miss('h80, 1); step();
        idle(); req_ready = 1; step();
        idle(); send_beat(0, 0); step();
        do_miss('h80, 3); inv_valid = 1; inv_paddr = 'h80;
        #1 chk("t5_merged", miss_merged, 0); chk("t5_ready", miss_ready, 1);
        step();
        idle(); req_ready = 1; send_beat(0, 1); step();
        for (int b = 0; b < NB; b++) begin idle(); send_beat(1, b); step(); end
        repeat (3) begin idle(); fill_ready = 1; step(); end

        // 6: flush over a pending write, then reset mid-fill with a late beat.
        do_miss('h200, 2); step();
        idle(); req_ready = 1; step();
        for (int b = 0; b < NB; b++) begin idle(); send_beat(0, b); step(); end
        idle(); step();
        idle(); flush = 1; fill_ready = 1; step();
        idle(); #1 chk("t6_fill_gone", fill_valid, 0); chk("t6_outstanding", outstanding, 0); step();
        do_miss('h240, 0); step();
        idle(); req_ready = 1; step();
        idle(); send_beat(0, 0); step();
        idle(); rstn = 0; step();
        step();
        rstn = 1;
        idle(); send_beat(0, 1); step();
        idle(); #1 chk("t6_late_beat", outstanding, 0); step();

        // Randomized traffic over a small line pool so merges and invalidation hits happen.
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(99) < 40) begin
                miss_valid = 1; miss_paddr = AW'($urandom_range(1, 6) << 6); miss_way = WW'($urandom_range(N-1));
            end
            req_ready  = ($urandom_range(99) < 70);
            fill_ready = ($urandom_range(99) < 50);
            kill       = ($urandom_range(99) < 3);
            flush      = ($urandom_range(99) < 1);
            if ($urandom_range(99) < 5) begin inv_valid = 1; inv_paddr = AW'($urandom_range(1, 6) << 6); end
            l2_drive(45, 3);
            step();
        end

        // Drain: no new misses, full readiness, L2 delivers everything owed.
        guard = 0;
        do begin
            idle(); req_ready = 1; fill_ready = 1;
            l2_drive(100, 0);
            step();
            busy_m = 0;
            for (int e = 0; e < N; e++) if (m_used[e] || l2_pend[e]) busy_m = 1;
            guard++;
        end while (busy_m && guard < 500);
        idle(); #1
        chk("drain_outstanding", outstanding, 0);
        chk("drain_model_idle", busy_m, 0);
        step();
        repeat (2) step();
        chk("exp_queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sargantana_icache_mshr.md
Name: sargantana_icache_mshr

Overview:
- Parametrised miss-status holding register file for the Sargantana instruction cache.
- Replaces the single-outstanding-miss ifill path with up to N_MSHR concurrent line fills.
- Each fill request carries an ID; multi-beat fill responses are reassembled per entry.
- Secondary misses to an in-flight line are merged; kill and L2 invalidation are handled per entry.
- Sits between icache_ctrl/replace_unit (miss side) and the L2 ifill interface, and drives the cache array write port.

Parameters:
N_MSHR, 4, number of outstanding line misses (power of 2, >=2)
LINE_ADDR_W, 34, physical line address width (paddr without the 6-bit line offset)
N_WAY, 4, cache associativity; WAY_W = $clog2(N_WAY)
BEAT_W, 256, fill response beat width
N_BEATS, 2, beats per cache line; LINE_W = N_BEATS*BEAT_W; ID_W = $clog2(N_MSHR)

Ports:
clk_i  in  1  clock
rstn_i  in  1  synchronous active-low reset
kill_i  in  1  core kill/redirect; drops every entry not in WRITE
flush_i  in  1  icache flush; drops every entry, including those in WRITE
miss_valid_i  in  1  primary miss from icache_ctrl
miss_ready_o  out  1  miss accepted when valid&ready
miss_paddr_i  in  LINE_ADDR_W  missing line address
miss_way_i  in  WAY_W  victim way chosen by replace unit
miss_merged_o  out  1  pulse: the accepted miss matched an in-flight entry
ifill_req_valid_o  out  1  request to L2
ifill_req_ready_i  in  1  L2 accepts request
ifill_req_paddr_o  out  LINE_ADDR_W  requested line
ifill_req_id_o  out  ID_W  entry index
ifill_resp_valid_i  in  1  response beat valid; always accepted, no backpressure
ifill_resp_id_i  in  ID_W  entry index
ifill_resp_beat_i  in  $clog2(N_BEATS)  beat number
ifill_resp_data_i  in  BEAT_W  beat data
inv_valid_i  in  1  L2 invalidation
inv_paddr_i  in  LINE_ADDR_W  invalidated line
fill_valid_o  out  1  completed line ready for the array write
fill_ready_i  in  1  array write port granted
fill_paddr_o  out  LINE_ADDR_W  line address (tag and index)
fill_way_o  out  WAY_W  way to write
fill_data_o  out  LINE_W  assembled line
outstanding_o  out  ID_W+1  number of non-FREE entries
busy_o  out  1  outstanding_o != 0

Behaviour:
- Reset: clock and reset are clk_i and rstn_i; reset is synchronous and active-low. While reset is asserted, all entries go FREE and the drop and beat masks clear. All outputs are 0, except miss_ready_o, which is 1 from the first cycle after reset.
- Entry states and transitions:
  - FREE -> WAIT_SEND on allocation.
  - WAIT_SEND -> WAIT_RESP on ifill handshake.
  - WAIT_RESP -> FILL on the first beat.
  - FILL -> WRITE when all N_BEATS beats are received, any order, tracked by a beat mask.
  - WRITE -> FREE on fill handshake.
  - If drop is set when the last beat arrives: FILL/WAIT_RESP -> FREE directly.
- Matching:
  - match = miss_paddr_i equals the paddr of a non-FREE entry with drop=0.
  - A match is accepted with miss_merged_o=1 and allocates nothing.
  - Otherwise the lowest-index FREE entry is allocated.
  - miss_ready_o = match | any FREE.
- Arbitration:
  - ifill_req presents the lowest-index WAIT_SEND entry.
  - fill presents the lowest-index WRITE entry.
  - valid/paddr/id are held stable until the handshake.
- Latency:
  - Miss accepted in cycle T: ifill_req_valid_o=1 in T+1 at the earliest.
  - Last beat in cycle T: fill_valid_o=1 in T+1 at the earliest.
- Freed slots: an entry freed in cycle T is allocatable in T+1, not in T.
- kill_i (per entry, in the assertion cycle):
  - WAIT_SEND -> FREE; the request is never issued.
  - WAIT_RESP/FILL set drop=1. The entry keeps absorbing beats and returns to FREE, never entering WRITE.
  - WRITE entries are unaffected.
  - A miss presented in the same cycle as kill_i is not accepted (miss_ready_o=0).
- flush_i: same as kill_i, and in addition WRITE entries -> FREE without issuing the fill. flush_i has priority over fill_ready_i.
- inv_valid_i: sets drop=1 on any non-FREE entry whose paddr matches. If the match is in WRITE, that entry -> FREE and fill_valid_o deasserts the same cycle.
- Simultaneous miss and invalidation to the same line: invalidation has priority. The miss allocates a fresh entry; there is no merge into the dropped entry.
- Spurious traffic: a response beat to a FREE entry, or a duplicate beat, is ignored and the data is discarded.
- Full: all entries non-FREE and no match -> miss_ready_o=0. This is not an error.

Test Plan:
1. Single miss to 0x1000, way 2 -> ifill_req id 0 the next cycle. Beats 0 then 1 return -> fill_valid_o with fill_paddr_o=0x1000, way=2, data={beat1,beat0}. After fill_ready, outstanding_o=0.
2. Four misses 0x10,0x20,0x30,0x40 back to back -> ids 0..3, outstanding_o=4, fifth miss 0x50 sees miss_ready_o=0. Responses return id 2,0,3,1 with beats reversed -> fills emitted in completion order with correct data.
3. Miss 0x10, then a second miss 0x10 before the response -> miss_merged_o=1, outstanding_o stays 1, exactly one ifill request and one fill.
4. Two entries in WAIT_RESP plus one in WAIT_SEND, assert kill_i -> WAIT_SEND entry freed with no request; both responses arrive -> no fill_valid_o; outstanding_o reaches 0.
5. Entry in FILL for 0x80 plus inv_valid_i 0x80 the same cycle as a new miss 0x80 -> new entry allocated, the old entry is discarded on its last beat, and only the new entry writes.
6. Entry in WRITE with fill_ready_i=0, then flush_i -> fill_valid_o=0 the next cycle and the entry is FREE. Repeat with reset asserted mid-FILL -> all outputs 0 the next cycle and the late beats are ignored.
